// File: rtl/dm_arbiter_if.sv
// Bus between the data-memory arbiter, its two requesters and the memory.
// slave: arbiter view; master: requesters plus memory view.
interface dm_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [AW-1:0] dm_read_addr;
    logic [AW-1:0] dm_write_addr;
    logic [DW-1:0] dm_write_data;
    logic          dm_we;
    logic [DW-1:0] dm_read_data;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  dm_read_data,
        output ack0, ack1, rdata, busy,
        output dm_read_addr, dm_write_addr,
        output dm_write_data, dm_we
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output dm_read_data,
        input  ack0, ack1, rdata, busy,
        input  dm_read_addr, dm_write_addr,
        input  dm_write_data, dm_we
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the SISC data memory.
// Ports: clk, rst (async, active-high), bus (dm_arbiter_if.slave).
module dm_arbiter #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SET,
        WR_COMMIT,
        ACK
    } state_t;

    state_t        state_q, state_d;
    logic          cur_q, cur_d;
    logic          last_q, last_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          busy_q, busy_d;
    logic          we_q, we_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          any_req;
    logic          gnt;

    // On a tie the port not granted last wins; a lone requester always wins.
    assign any_req = bus.req0 | bus.req1;
    assign gnt     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        we_d    = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cur_d   = gnt;
                    last_d  = gnt;
                    addr_d  = gnt ? bus.addr1 : bus.addr0;
                    wdata_d = gnt ? bus.wdata1 : bus.wdata0;
                    if (gnt ? bus.we1 : bus.we0) begin
                        state_d = WR_SET;
                        we_d    = 1'b1;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rdata_d = bus.dm_read_data;
                ack0_d  = ~cur_q;
                ack1_d  = cur_q;
                state_d = ACK;
            end
            // dm_we drops on entry to WR_COMMIT; that fall is the commit.
            WR_SET: state_d = WR_COMMIT;
            WR_COMMIT: begin
                ack0_d  = ~cur_q;
                ack1_d  = cur_q;
                state_d = ACK;
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Address/data survive reset so a write interrupted in WR_SET
    // still lands where it was aimed when dm_we is forced low.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign bus.ack0          = ack0_q;
    assign bus.ack1          = ack1_q;
    assign bus.rdata         = rdata_q;
    assign bus.busy          = busy_q;
    assign bus.dm_we         = we_q;
    assign bus.dm_read_addr  = addr_q;
    assign bus.dm_write_addr = addr_q;
    assign bus.dm_write_data = wdata_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Testbench for dm_arbiter with a behavioural data memory.
// Expected acks are queued at stimulus time and popped on each ack.
module tb_dm_arbiter;
    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    int   viol = 0;
    bit   mem_en = 1'b0;
    exp_t sb[$];
    logic [DW-1:0] mem [0:255];

    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    dm_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.dm_read_data = mem[bus.dm_read_addr[7:0]];

    always @(negedge bus.dm_we)
        if (mem_en) mem[bus.dm_write_addr[7:0]] = bus.dm_write_data;

    always @(negedge clk)
        if (!rst) begin
            if (bus.ack0 && bus.ack1) viol++;
            if (bus.dm_we && !bus.busy) viol++;
        end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_txn(input bit port, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] rd,
                          output int we_cyc, output bit oth);
        lat = -1;
        rd = '0;
        we_cyc = 0;
        oth = 1'b0;
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.dm_we) we_cyc++;
            if (port ? bus.ack0 : bus.ack1) oth = 1'b1;
            if (port ? bus.ack1 : bus.ack0) begin
                lat = i;
                rd = bus.rdata;
                break;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
        checks++; if (bus.ack0 !== 1'b0) $display("FAIL reset_ack0: got %b want 0", bus.ack0); else passed++;
        checks++; if (bus.ack1 !== 1'b0) $display("FAIL reset_ack1: got %b want 0", bus.ack1); else passed++;
        checks++; if (bus.dm_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus.dm_we); else passed++;
        checks++; if (bus.rdata !== '0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else passed++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        int lat; logic [DW-1:0] rd; int wc; bit oth; exp_t e;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        do_txn(1'b0, 1'b0, 16'h0004, '0, lat, rd, wc, oth);
        e = sb.pop_front();
        checks++; if (lat !== 2) $display("FAIL read_lat: got %0d want 2", lat); else passed++;
        checks++; if (rd !== e.data) $display("FAIL read_data: got %h want %h", rd, e.data); else passed++;
        checks++; if (wc !== 0) $display("FAIL read_we: got %0d want 0", wc); else passed++;
        checks++; if (oth !== 1'b0) $display("FAIL read_ack1: got %b want 0", oth); else passed++;
    endtask

    task automatic test_write_readback();
        int lat; logic [DW-1:0] rd; int wc; bit oth; exp_t e;
        do_txn(1'b1, 1'b1, 16'h0010, 32'h12345678, lat, rd, wc, oth);
        checks++; if (lat !== 3) $display("FAIL wr_lat: got %0d want 3", lat); else passed++;
        checks++; if (wc !== 1) $display("FAIL wr_we_cycles: got %0d want 1", wc); else passed++;
        checks++; if (bus.dm_write_addr !== 16'h0010) $display("FAIL wr_addr: got %h want 0010", bus.dm_write_addr); else passed++;
        checks++; if (oth !== 1'b0) $display("FAIL wr_ack0: got %b want 0", oth); else passed++;
        sb.push_back('{1'b1, 32'h12345678});
        do_txn(1'b1, 1'b0, 16'h0010, '0, lat, rd, wc, oth);
        e = sb.pop_front();
        checks++; if (lat !== 2) $display("FAIL rb_lat: got %0d want 2", lat); else passed++;
        checks++; if (rd !== e.data) $display("FAIL rb_data: got %h want %h", rd, e.data); else passed++;
    endtask

    task automatic test_tie();
        int n = 0; int prev = -1; bit idle_chk = 1'b0; exp_t e; logic p;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, 32'hDEADBEEF});
            sb.push_back('{1'b1, 32'h12345678});
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0010;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(posedge clk); #1;
            if (idle_chk) begin
                idle_chk = 1'b0;
                checks++; if (bus.busy !== 1'b0) $display("FAIL tie_idle: got busy %b want 0", bus.busy); else passed++;
            end
            if (bus.ack0 || bus.ack1) begin
                p = bus.ack1;
                e = sb.pop_front();
                checks++; if (p !== e.port) $display("FAIL tie_grant%0d: got %b want %b", n, p, e.port); else passed++;
                checks++; if (bus.rdata !== e.data) $display("FAIL tie_data%0d: got %h want %h", n, bus.rdata, e.data); else passed++;
                if (prev >= 0) begin
                    checks++; if (i - prev !== 3) $display("FAIL tie_gap%0d: got %0d want 3", n, i - prev); else passed++;
                end
                prev = i;
                idle_chk = 1'b1;
                n++;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++; if (n !== 4) $display("FAIL tie_count: got %0d want 4", n); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) $display("FAIL tie_end_idle: got %b want 0", bus.busy); else passed++;
        sb.delete();
    endtask

    task automatic test_held_req();
        int n = 0; int prev = -1; exp_t e;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b0, 32'hDEADBEEF});
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0004;
        for (int i = 0; i < 20 && n < 2; i++) begin
            @(posedge clk); #1;
            if (bus.ack0) begin
                e = sb.pop_front();
                checks++; if (bus.rdata !== e.data) $display("FAIL held_data%0d: got %h want %h", n, bus.rdata, e.data); else passed++;
                if (prev >= 0) begin
                    checks++; if (i - prev !== 3) $display("FAIL held_gap: got %0d want 3", i - prev); else passed++;
                end
                prev = i;
                n++;
            end
        end
        bus.req0 = 1'b0;
        checks++; if (n !== 2) $display("FAIL held_count: got %0d want 2", n); else passed++;
        @(posedge clk); #1;
        sb.delete();
    endtask

    task automatic test_reset_wr_set();
        int lat; logic [DW-1:0] rd; int wc; bit oth;
        bus.req0 = 1'b1; bus.we0 = 1'b1;
        bus.addr0 = 16'h0020; bus.wdata0 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        checks++; if (bus.dm_we !== 1'b1) $display("FAIL rw_we_set: got %b want 1", bus.dm_we); else passed++;
        #2 rst = 1'b1;
        #1;
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        checks++; if (bus.dm_we !== 1'b0) $display("FAIL rw_we_fall: got %b want 0", bus.dm_we); else passed++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rw_busy: got %b want 0", bus.busy); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.ack0 !== 1'b0) $display("FAIL rw_noack: got %b want 0", bus.ack0); else passed++;
        checks++; if (bus.rdata !== '0) $display("FAIL rw_rdata: got %h want 0", bus.rdata); else passed++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_txn(1'b0, 1'b0, 16'h0020, '0, lat, rd, wc, oth);
        checks++; if (rd !== 32'hA5A5A5A5) $display("FAIL rw_commit: got %h want a5a5a5a5", rd); else passed++;
        checks++; if (lat !== 2) $display("FAIL rw_lat: got %0d want 2", lat); else passed++;
    endtask

    task automatic test_reset_rd();
        int lat; logic [DW-1:0] rd; int wc; bit oth;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0030;
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL rr_busy: got %b want 1", bus.busy); else passed++;
        #2 rst = 1'b1;
        #1;
        bus.req0 = 1'b0;
        checks++; if (bus.rdata !== '0) $display("FAIL rr_rdata: got %h want 0", bus.rdata); else passed++;
        @(posedge clk); #1;
        checks++; if (bus.ack0 !== 1'b0) $display("FAIL rr_noack: got %b want 0", bus.ack0); else passed++;
        checks++; if (mem[8'h30] !== 32'h11223344) $display("FAIL rr_mem: got %h want 11223344", mem[8'h30]); else passed++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        do_txn(1'b1, 1'b0, 16'h0030, '0, lat, rd, wc, oth);
        checks++; if (rd !== 32'h11223344) $display("FAIL rr_after: got %h want 11223344", rd); else passed++;
        checks++; if (lat !== 2) $display("FAIL rr_lat: got %0d want 2", lat); else passed++;
    endtask

    task automatic test_invariants();
        checks++; if (viol !== 0) $display("FAIL invariants: got %0d violations want 0", viol); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h30] = 32'h11223344;
        mem_en = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        test_reset();
        test_read();
        test_write_readback();
        test_tie();
        test_held_req();
        test_reset_wr_set();
        test_reset_rd();
        test_invariants();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
